sdram_req_arbiter: RTL and testbench

//  Shares the SDRAM core's application command interface (sdram_write_enable, sdram_read_enable, app_address)

---
 rtl/sdram_req_arbiter_pkg.sv | 19 +
 rtl/sdram_req_arbiter_if.sv | 39 +++
 rtl/sdram_req_arbiter_hold_timer.sv | 32 +++
 rtl/sdram_req_arbiter.sv | 132 +++++++++++++
 tb/tb_sdram_req_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sdram_req_arbiter_pkg.sv
// Shared types and helpers for the two-requester SDRAM command arbiter.
package sdram_req_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_RUN   = 2'd1,
      ARB_DRAIN = 2'd2
   } arb_state_e;

   localparam logic OWNER_0 = 1'b0;
   localparam logic OWNER_1 = 1'b1;

   // Round-robin pick: on a tie the requester that did not own last wins.
   function automatic logic pick_owner(input logic act0, input logic act1, input logic last);
      if (act0 && act1) return ~last;
      return act1 ? OWNER_1 : OWNER_0;
   endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Requester and SDRAM-core side signals of the arbiter.
interface sdram_req_arbiter_if #(
   parameter int ADDR_WIDTH = 22
);
   logic                  sdram_ready;
   logic                  core_idle;
   logic                  req0_write;
   logic                  req0_read;
   logic [ADDR_WIDTH-1:0] req0_address;
   logic                  req0_grant;
   logic                  req0_yield;
   logic                  req1_write;
   logic                  req1_read;
   logic [ADDR_WIDTH-1:0] req1_address;
   logic                  req1_grant;
   logic                  req1_yield;
   logic                  sdram_write_enable;
   logic                  sdram_read_enable;
   logic [ADDR_WIDTH-1:0] app_address;
   logic                  err_conflict;

   // Requesters and core status drive this side.
   modport master (
      output sdram_ready, core_idle,
      output req0_write, req0_read, req0_address,
      output req1_write, req1_read, req1_address,
      input  req0_grant, req0_yield, req1_grant, req1_yield,
      input  sdram_write_enable, sdram_read_enable, app_address, err_conflict
   );

   // The arbiter itself.
   modport slave (
      input  sdram_ready, core_idle,
      input  req0_write, req0_read, req0_address,
      input  req1_write, req1_read, req1_address,
      output req0_grant, req0_yield, req1_grant, req1_yield,
      output sdram_write_enable, sdram_read_enable, app_address, err_conflict
   );
endinterface

// File: rtl/sdram_req_arbiter_hold_timer.sv
// Saturating hold counter; reach_o flags the cycle the count arrives at MAX_HOLD.
module sdram_req_arbiter_hold_timer #(
   parameter int MAX_HOLD   = 1024,
   parameter int HOLD_WIDTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic reach_o
);
   logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;

   // Reaching the limit is flagged on the same edge the counter lands on it,
   // so the owner's yield rises exactly MAX_HOLD waiting cycles in.
   assign reach_o = en_i && !clr_i && (cnt_q >= HOLD_WIDTH'(MAX_HOLD - 1));

   // Next count: clear wins, otherwise count up and stick at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != HOLD_WIDTH'(MAX_HOLD)))
         cnt_d = cnt_q + HOLD_WIDTH'(1);
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin owner arbitration of the SDRAM core command interface between two requesters.
module sdram_req_arbiter
   import sdram_req_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 22,
   parameter int MAX_HOLD   = 1024,
   parameter int HOLD_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   sdram_req_arbiter_if.slave bus
);
   arb_state_e            state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_q, last_d;
   logic [1:0]            grant_q, grant_d;
   logic                  yield_q, yield_d;
   logic                  we_q, we_d, re_q, re_d;
   logic                  err_q, err_d;
   logic                  conf_q, conf_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  act0, act1, own_w, own_r, oth_act;
   logic                  hold_en, hold_reach;

   assign act0    = bus.req0_write | bus.req0_read;
   assign act1    = bus.req1_write | bus.req1_read;
   assign own_w   = owner_q ? bus.req1_write : bus.req0_write;
   assign own_r   = owner_q ? bus.req1_read  : bus.req0_read;
   assign oth_act = owner_q ? act0 : act1;

   // Time only while someone owns the core and the other side is waiting.
   assign hold_en = (state_q == ARB_RUN) && bus.sdram_ready && oth_act;

   sdram_req_arbiter_hold_timer #(
      .MAX_HOLD   (MAX_HOLD),
      .HOLD_WIDTH (HOLD_WIDTH)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (~hold_en),
      .en_i    (hold_en),
      .reach_o (hold_reach)
   );

   // Next state and registered outputs; loss of sdram_ready overrides everything.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      grant_d = grant_q;
      yield_d = yield_q;
      we_d    = 1'b0;
      re_d    = 1'b0;
      err_d   = 1'b0;
      conf_d  = conf_q;
      addr_d  = addr_q;
      if (!bus.sdram_ready) begin
         state_d = ARB_IDLE;
         grant_d = '0;
         yield_d = 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (bus.core_idle && (act0 || act1)) begin
                  owner_d = pick_owner(act0, act1, last_q);
                  addr_d  = owner_d ? bus.req1_address : bus.req0_address;
                  grant_d = owner_d ? 2'b10 : 2'b01;
                  yield_d = 1'b0;
                  conf_d  = 1'b0;
                  state_d = ARB_RUN;
               end
            end
            ARB_RUN: begin
               // Write has priority; a simultaneous read is flagged once per grant.
               we_d = own_w;
               re_d = own_r & ~own_w;
               if (own_w && own_r && !conf_q) begin
                  err_d  = 1'b1;
                  conf_d = 1'b1;
               end
               if (hold_reach) yield_d = 1'b1;
               if (!own_w && !own_r) state_d = ARB_DRAIN;
            end
            ARB_DRAIN: begin
               if (bus.core_idle) begin
                  grant_d = '0;
                  yield_d = 1'b0;
                  last_d  = owner_q;
                  state_d = ARB_IDLE;
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= OWNER_0;
         last_q  <= OWNER_1;
         grant_q <= '0;
         yield_q <= 1'b0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         err_q   <= 1'b0;
         conf_q  <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         yield_q <= yield_d;
         we_q    <= we_d;
         re_q    <= re_d;
         err_q   <= err_d;
         conf_q  <= conf_d;
         addr_q  <= addr_d;
      end
   end

   assign bus.req0_grant         = grant_q[0];
   assign bus.req1_grant         = grant_q[1];
   assign bus.req0_yield         = yield_q & grant_q[0];
   assign bus.req1_yield         = yield_q & grant_q[1];
   assign bus.sdram_write_enable = we_q;
   assign bus.sdram_read_enable  = re_q;
   assign bus.app_address        = addr_q;
   assign bus.err_conflict       = err_q;
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Randomised and directed checks of sdram_req_arbiter against a behavioural model.
module tb_sdram_req_arbiter;
   localparam int AW  = 22;
   localparam int MH  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sdram_req_arbiter_if #(.ADDR_WIDTH(AW)) bus();

   sdram_req_arbiter #(.ADDR_WIDTH(AW), .MAX_HOLD(MH), .HOLD_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: who owns the core (-1 none), whether it is draining, and derived outputs.
   int              m_own, m_last, m_wait;
   bit              m_drain, m_yld, m_conf_done, m_we, m_re, m_err;
   logic [AW-1:0]   m_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own = -1; m_last = 1; m_wait = 0;
      m_drain = 0; m_yld = 0; m_conf_done = 0;
      m_we = 0; m_re = 0; m_err = 0; m_addr = '0;
   endtask

   // One clock of the arbiter's rules, applied to the inputs held across the edge.
   task automatic model_step(input bit r, input bit ci, input bit w0, input bit r0,
                             input logic [AW-1:0] a0, input bit w1, input bit r1,
                             input logic [AW-1:0] a1);
      bit act[2], ow, orr;
      act[0] = w0 | r0;
      act[1] = w1 | r1;
      m_err = 0;
      if (!r) begin
         m_own = -1; m_drain = 0; m_we = 0; m_re = 0; m_yld = 0; m_wait = 0;
         return;
      end
      if (m_own < 0) begin
         m_we = 0; m_re = 0;
         if (ci && (act[0] || act[1])) begin
            m_own = (act[0] && act[1]) ? 1 - m_last : (act[1] ? 1 : 0);
            m_addr = (m_own == 1) ? a1 : a0;
            m_conf_done = 0; m_wait = 0; m_yld = 0;
         end
      end else if (!m_drain) begin
         ow  = (m_own == 1) ? w1 : w0;
         orr = (m_own == 1) ? r1 : r0;
         m_we = ow;
         m_re = orr && !ow;
         if (ow && orr && !m_conf_done) begin
            m_err = 1; m_conf_done = 1;
         end
         if (act[1 - m_own]) begin
            if (m_wait < MH) m_wait++;
            if (m_wait == MH) m_yld = 1;
         end else m_wait = 0;
         if (!ow && !orr) m_drain = 1;
      end else begin
         m_we = 0; m_re = 0; m_wait = 0;
         if (ci) begin
            m_last = m_own; m_own = -1; m_drain = 0; m_yld = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("req0_grant", 32'(bus.req0_grant), 32'(m_own == 0));
      chk("req1_grant", 32'(bus.req1_grant), 32'(m_own == 1));
      chk("req0_yield", 32'(bus.req0_yield), 32'(m_yld && m_own == 0));
      chk("req1_yield", 32'(bus.req1_yield), 32'(m_yld && m_own == 1));
      chk("write_en",   32'(bus.sdram_write_enable), 32'(m_we));
      chk("read_en",    32'(bus.sdram_read_enable),  32'(m_re));
      chk("err_conf",   32'(bus.err_conflict),       32'(m_err));
      if (m_own >= 0) chk("app_addr", 32'(bus.app_address), 32'(m_addr));
      chk("one_grant",  32'(bus.req0_grant & bus.req1_grant), 32'd0);
   endtask

   // Apply one cycle of inputs, advance the model and the DUT, then compare.
   task automatic cyc(input bit r, input bit ci, input bit w0, input bit r0,
                      input logic [AW-1:0] a0, input bit w1, input bit r1,
                      input logic [AW-1:0] a1);
      bus.sdram_ready = r;  bus.core_idle = ci;
      bus.req0_write = w0;  bus.req0_read = r0;  bus.req0_address = a0;
      bus.req1_write = w1;  bus.req1_read = r1;  bus.req1_address = a1;
      model_step(r, ci, w0, r0, a0, w1, r1, a1);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.sdram_ready = 0; bus.core_idle = 0;
      bus.req0_write = 0; bus.req0_read = 0; bus.req0_address = '0;
      bus.req1_write = 0; bus.req1_read = 0; bus.req1_address = '0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      bit rw_w[2], rw_r[2];
      int m;
      logic [AW-1:0] ra0, ra1;

      // 1: single write request, grant and address next cycle, enable one later.
      do_reset();
      cyc(1, 1, 1, 0, 22'h000100, 0, 0, 22'h0);
      chk("t1_grant", 32'(bus.req0_grant), 32'd1);
      chk("t1_addr",  32'(bus.app_address), 32'h000100);
      chk("t1_we0",   32'(bus.sdram_write_enable), 32'd0);
      cyc(1, 1, 1, 0, 22'h3AAAAA, 0, 0, 22'h0);
      chk("t1_we1",   32'(bus.sdram_write_enable), 32'd1);
      chk("t1_hold",  32'(bus.app_address), 32'h000100);
      cyc(1, 1, 0, 0, 22'h0, 0, 0, 22'h0);
      cyc(1, 1, 0, 0, 22'h0, 0, 0, 22'h0);

      // 2: simultaneous reads from reset: req0 first, req1 after req0 drains.
      do_reset();
      cyc(1, 1, 0, 1, 22'h11, 0, 1, 22'h22);
      chk("t2_first", 32'(bus.req0_grant), 32'd1);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 22'h11, 0, 1, 22'h22);
      cyc(1, 1, 0, 0, 22'h0, 0, 1, 22'h22);
      cyc(1, 1, 0, 0, 22'h0, 0, 1, 22'h22);
      cyc(1, 1, 0, 0, 22'h0, 0, 1, 22'h22);
      chk("t2_second", 32'(bus.req1_grant), 32'd1);
      chk("t2_addr",   32'(bus.app_address), 32'h22);
      cyc(1, 1, 0, 0, 22'h0, 0, 0, 22'h0);
      cyc(1, 1, 0, 0, 22'h0, 0, 0, 22'h0);

      // 3: drain waits on core_idle for five cycles.
      cyc(1, 1, 1, 0, 22'h55, 0, 0, 22'h0);
      cyc(1, 1, 1, 0, 22'h55, 0, 0, 22'h0);
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, 0, 0, 22'h0, 0, 0, 22'h0);
         chk("t3_held", 32'(bus.req0_grant), 32'd1);
      end
      cyc(1, 1, 0, 0, 22'h0, 0, 0, 22'h0);
      chk("t3_rel", 32'(bus.req0_grant), 32'd0);

      // 4: yield after MH waiting cycles, grant kept until owner drops.
      cyc(1, 1, 1, 0, 22'h77, 0, 0, 22'h0);
      for (int i = 1; i <= MH + 3; i++) begin
         cyc(1, 1, 1, 0, 22'h77, 0, 1, 22'h88);
         chk("t4_yield", 32'(bus.req0_yield), 32'(i >= MH));
      end
      chk("t4_grant", 32'(bus.req0_grant), 32'd1);
      cyc(1, 1, 0, 0, 22'h0, 0, 1, 22'h88);
      cyc(1, 1, 0, 0, 22'h0, 0, 1, 22'h88);
      cyc(1, 1, 0, 0, 22'h0, 0, 1, 22'h88);

      // 5: owner (req1 now) asserts read and write together.
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 22'h0, 1, 1, 22'h99);
      cyc(1, 1, 0, 0, 22'h0, 0, 0, 22'h0);
      cyc(1, 1, 0, 0, 22'h0, 0, 0, 22'h0);

      // 6: sdram_ready drops mid-run; nothing granted until it returns.
      cyc(1, 1, 0, 1, 22'h44, 0, 0, 22'h0);
      cyc(1, 1, 0, 1, 22'h44, 0, 0, 22'h0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 22'h44, 0, 1, 22'h66);
      cyc(1, 1, 0, 1, 22'h44, 0, 1, 22'h66);
      cyc(1, 1, 0, 0, 22'h0, 0, 0, 22'h0);
      cyc(1, 1, 0, 0, 22'h0, 0, 0, 22'h0);

      // Random bursts from both requesters with noisy ready/idle and addresses.
      rw_w = '{0, 0}; rw_r = '{0, 0};
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (rw_w[k] || rw_r[k]) begin
               if ($urandom_range(0, 7) == 0) begin rw_w[k] = 0; rw_r[k] = 0; end
            end else if ($urandom_range(0, 3) == 0) begin
               m = $urandom_range(0, 15);
               rw_w[k] = (m < 7) || (m == 15);
               rw_r[k] = (m >= 7);
            end
         end
         ra0 = AW'($urandom);
         ra1 = AW'($urandom);
         cyc($urandom_range(0, 40) != 0, $urandom_range(0, 9) < 7,
             rw_w[0], rw_r[0], ra0, rw_w[1], rw_r[1], ra1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
